// File: rtl/dmem_unit.sv
// Handshaked data memory for the MEM stage: configurable depth and wait states, registered response.
// Define DMEM_SUBWORD_EN to enable byte/halfword lanes with sign/zero extension.
module dmem_unit #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic        accept, commit;
  logic        cur_we, cur_signed;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;
  logic [AW-1:0] idx;
  logic        range_err, align_err, err;
  logic [3:0]  be;
  logic [31:0] wdata_lane, word_rd, load_data;

  assign accept = (state_q == StIdle) && req_valid;

  // With zero wait states the commit happens on the accepting edge, so use the port directly.
  assign cur_we     = (state_q == StIdle) ? req_we     : we_q;
  assign cur_size   = (state_q == StIdle) ? req_size   : size_q;
  assign cur_signed = (state_q == StIdle) ? req_signed : signed_q;
  assign cur_addr   = (state_q == StIdle) ? req_addr   : addr_q;
  assign cur_wdata  = (state_q == StIdle) ? req_wdata  : wdata_q;

  assign idx       = cur_addr[AW+1:2];
  assign range_err = ({2'b00, cur_addr[31:2]} >= DEPTH);
  assign err       = range_err | align_err;
  assign word_rd   = mem[idx];

`ifdef DMEM_SUBWORD_EN
  logic [31:0] rd_sh;
  assign rd_sh = word_rd >> {cur_addr[1:0], 3'b000};

  always_comb begin
    align_err  = 1'b0;
    be         = 4'b0000;
    wdata_lane = '0;
    load_data  = '0;
    unique case (cur_size)
      2'd0: begin
        be         = 4'b0001 << cur_addr[1:0];
        wdata_lane = {24'b0, cur_wdata[7:0]} << {cur_addr[1:0], 3'b000};
        load_data  = {{24{cur_signed & rd_sh[7]}}, rd_sh[7:0]};
      end
      2'd1: begin
        align_err  = cur_addr[0];
        be         = 4'b0011 << cur_addr[1:0];
        wdata_lane = {16'b0, cur_wdata[15:0]} << {cur_addr[1:0], 3'b000};
        load_data  = {{16{cur_signed & rd_sh[15]}}, rd_sh[15:0]};
      end
      2'd2: begin
        align_err  = (cur_addr[1:0] != 2'b00);
        be         = 4'b1111;
        wdata_lane = cur_wdata;
        load_data  = word_rd;
      end
      default: align_err = 1'b1;
    endcase
  end
`else
  logic unused_subword;
  assign unused_subword = ^{cur_size, cur_signed};
  assign align_err  = (cur_addr[1:0] != 2'b00);
  assign be         = 4'b1111;
  assign wdata_lane = cur_wdata;
  assign load_data  = word_rd;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (commit) begin
        err_q   <= err;
        rdata_q <= (err || cur_we) ? '0 : load_data;
      end
    end
  end

  // Array has no reset; contents survive rst_n.
  always_ff @(posedge clk1) begin
    if (commit && !err && cur_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Randomized and directed bench for dmem_unit; two instances (1 and 0 wait states) vs. a byte-level model.
module tb_dmem_unit;
  localparam int unsigned DEPTH = 128;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  bit          sel = 1'b0;  // 0 -> u_ws1, 1 -> u_ws0

  logic        valid0, valid1, ready0, ready1, rv0, rv1, err0, err1, busy0, busy1;
  logic [31:0] rd0, rd1;
  logic        v_ready, v_rsp_valid, v_err, v_busy;
  logic [31:0] v_rdata;

  logic [31:0] ref_mem [2][DEPTH];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] rd;
  logic        er;

  always #5 clk1 = ~clk1;

  assign valid1      = req_valid & ~sel;
  assign valid0      = req_valid & sel;
  assign v_ready     = sel ? ready0 : ready1;
  assign v_rsp_valid = sel ? rv0 : rv1;
  assign v_err       = sel ? err0 : err1;
  assign v_busy      = sel ? busy0 : busy1;
  assign v_rdata     = sel ? rd0 : rd1;

  dmem_unit #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk1(clk1), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1), .busy(busy1)
  );

  dmem_unit #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk1(clk1), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_word(input bit s, input int i, input logic [31:0] v);
    if (s) u_ws0.mem[i] <= v;
    else   u_ws1.mem[i] <= v;
    ref_mem[s][i] = v;
  endtask

  function automatic logic [31:0] get_word(input bit s, input int i);
    return s ? u_ws0.mem[i] : u_ws1.mem[i];
  endfunction

  // Byte-addressed reference: access is nb bytes starting at addr, little-endian.
  task automatic model(input bit s, input logic we, input logic [1:0] size, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata);
    int nb, widx, lane;
    logic [63:0] v;
`ifdef DMEM_SUBWORD_EN
    nb = (size == 2'd3) ? 0 : (1 << size);
`else
    nb = 4;
`endif
    widx  = int'(addr >> 2);
    lane  = int'(addr[1:0]);
    rdata = '0;
    if (nb == 0) err = 1'b1;
    else err = ((addr >> 2) >= DEPTH) || ((addr % nb) != 0);
    if (!err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) ref_mem[s][widx][8*(lane+k) +: 8] = wdata[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v = v | (64'(ref_mem[s][widx][8*(lane+k) +: 8]) << (8*k));
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        rdata = v[31:0];
      end
    end
  endtask

  task automatic do_req(input bit s, input logic we, input logic [1:0] size, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdo, output logic ero);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          lat;
    model(s, we, size, sg, addr, wdata, exp_err, exp_rd);
    @(negedge clk1);
    sel = s; req_we = we; req_size = size; req_signed = sg; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    check("req_ready", v_ready, 1);
    @(negedge clk1);
    req_valid = 1'b0;
    check("busy", v_busy, 1);
    lat = 1;
    while (!v_rsp_valid && lat < 20) begin
      @(negedge clk1);
      lat++;
    end
    check("latency", lat, s ? 1 : 2);
    check("rsp_err", v_err, exp_err);
    check("rsp_rdata", v_rdata, exp_rd);
    rdo = v_rdata;
    ero = v_err;
    @(negedge clk1);
    check("rsp_pulse", v_rsp_valid, 0);
    check("rdata_hold", v_rdata, exp_rd);
  endtask

  task automatic hold_test(input bit s);
    int acc, rsp, bad, p;
    p = s ? 2 : 3;
    @(negedge clk1);
    sel = s; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'd400;
    req_valid = 1'b1;
    acc = 0; rsp = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (v_ready) acc++;
      if (v_busy === v_ready) bad++;
      if (v_rsp_valid) rsp++;
      @(negedge clk1);
    end
    req_valid = 1'b0;
    check("hold_accepts", acc, (12 + p - 1) / p);
    check("hold_rsps", rsp, (12 + p - 1) / p);
    check("hold_busy", bad, 0);
    @(negedge clk1);
  endtask

  initial begin
    int n, nbad;
    logic [31:0] a;
    for (int i = 0; i < int'(DEPTH); i++) begin
      set_word(0, i, $urandom());
      set_word(1, i, $urandom());
    end
    repeat (2) @(negedge clk1);
    check("rst_ready", v_ready, 1);
    check("rst_rsp_valid", v_rsp_valid, 0);
    check("rst_err", v_err, 0);
    check("rst_rdata", v_rdata, 0);
    check("rst_busy", v_busy, 0);
    rst_n = 1'b1;
    @(negedge clk1);

    do_req(0, 1, 2, 0, 32'd400, 32'd5555, rd, er);
    check("sw_err", er, 0);
    check("sw_word100", get_word(0, 100), 32'd5555);
    do_req(0, 0, 2, 0, 32'd400, 32'd0, rd, er);
    check("lw_400", rd, 32'd5555);
`ifndef DMEM_SUBWORD_EN
    do_req(0, 0, 0, 0, 32'd400, 32'd0, rd, er);
    check("nosub_lb_data", rd, 32'd5555);
    check("nosub_lb_err", er, 0);
    do_req(0, 0, 0, 0, 32'd401, 32'd0, rd, er);
    check("nosub_401_err", er, 1);
`else
    set_word(0, 100, 32'h80FF_7F01);
    @(negedge clk1);
    do_req(0, 0, 0, 1, 32'd403, 32'd0, rd, er);
    check("lb_403", rd, 32'hFFFF_FF80);
    do_req(0, 0, 0, 0, 32'd403, 32'd0, rd, er);
    check("lbu_403", rd, 32'h0000_0080);
    do_req(0, 0, 1, 1, 32'd402, 32'd0, rd, er);
    check("lh_402", rd, 32'hFFFF_80FF);
    do_req(0, 1, 0, 0, 32'd401, 32'h1234_56AA, rd, er);
    check("sb_401", get_word(0, 100), 32'h80FF_AA01);
    do_req(0, 0, 3, 0, 32'd16, 32'd0, rd, er);
    check("size3_err", er, 1);
`endif
    do_req(0, 0, 2, 0, 32'd402, 32'd0, rd, er);
    check("lw_402_err", er, 1);
    check("lw_402_rdata", rd, 0);
    do_req(0, 1, 2, 0, 4 * DEPTH, 32'hDEAD_BEEF, rd, er);
    check("sw_oob_err", er, 1);

    do_req(1, 1, 2, 0, 32'd400, 32'h0BAD_F00D, rd, er);
    do_req(1, 0, 2, 0, 32'd400, 32'd0, rd, er);
    check("ws0_lw", rd, 32'h0BAD_F00D);

    hold_test(0);
    hold_test(1);

    // Reset during the wait state of a store.
    do_req(0, 0, 2, 0, 32'd400, 32'd0, rd, er);
    @(negedge clk1);
    sel = 0; req_we = 1'b1; req_size = 2'd2; req_addr = 32'd8; req_wdata = 32'h1234;
    req_valid = 1'b1;
    @(negedge clk1);
    req_valid = 1'b0;
    check("mid_busy", v_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", v_ready, 1);
    check("mid_rst_busy", v_busy, 0);
    check("mid_rst_valid", v_rsp_valid, 0);
    check("mid_rst_err", v_err, 0);
    check("mid_rst_rdata", v_rdata, 0);
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk1);
      if (v_rsp_valid) n++;
    end
    check("mid_rst_no_rsp", n, 0);
    check("mid_rst_word2", get_word(0, 2), ref_mem[0][2]);

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 120; k++) begin
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4 * DEPTH + 15))
                                        : 32'($urandom_range(0, 63));
        do_req(bit'(s), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), a, $urandom(), rd, er);
      end
    end

    for (int s = 0; s < 2; s++) begin
      nbad = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (get_word(bit'(s), i) !== ref_mem[s][i]) nbad++;
      end
      check("mem_sweep", nbad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
